latch_edge_capture: RTL and testbench
=====================================

LATCH_EDGE_CAPTURE -- requirements
Module: latch_edge_capture

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting event FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TSW, default 8, setting the timestamp width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clrn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port q, input, 1 bit: D-latch output, asynchronous to clk.
REQ-006 The block SHALL have port ev_ready, input, 1 bit: consumer accepts the head event.
REQ-007 The block SHALL have port ev_valid, output, 1 bit: FIFO non-empty; head event present on ev_data.
REQ-008 The block SHALL have port ev_data, output, TSW+2 bits: {rise, fall, timestamp[TSW-1:0]}.
REQ-009 The block SHALL have port overflow, output, 1 bit: sticky flag, an event was dropped.
REQ-010 The block SHALL have port level, output, 1 bit: synchronised value of q.

Function
REQ-011 q SHALL pass through a two-flop synchroniser (s1, s2); s3 SHALL hold the previous s2; level SHALL equal s2.
REQ-012 The FSM SHALL have states PRIME0, PRIME1 and RUN; reset enters PRIME0, then PRIME0->PRIME1->RUN on successive edges; RUN is held until reset.
REQ-013 In PRIME0/PRIME1 the synchroniser SHALL update but no event SHALL be pushed (no spurious edge after reset).
REQ-014 In RUN, s2=1,s3=0 SHALL push {1,0,ts}; s2=0,s3=1 SHALL push {0,1,ts}; rise and fall are never both 1.
REQ-015 Latency: q stable across edge k SHALL produce ev_valid=1 after edge k+2 (empty FIFO, RUN).
REQ-016 A pop SHALL occur on an edge where ev_valid=1 and ev_ready=1; ev_ready with empty FIFO SHALL be ignored.
REQ-017 ev_data SHALL stay stable while ev_valid=1 and ev_ready=0.
REQ-018 Push to a full FIFO without a pop SHALL drop the new event and set overflow; stored entries are unchanged.
REQ-019 Simultaneous push and pop when full SHALL both succeed; the count stays DEPTH and overflow is unaffected.
REQ-020 Simultaneous push and pop when empty SHALL be a push only (ev_valid was 0).
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-022 Timestamp ts SHALL be a free-running TSW-bit counter incrementing every clock, wrapping 2^TSW-1 -> 0; the event SHALL record ts before increment.

Reset
REQ-023 With clrn=0 at an edge: s1=s2=s3=0, state=PRIME0, FIFO empty, ts=0, overflow=0.
REQ-024 Outputs after reset SHALL be ev_valid=0, ev_data=0, overflow=0, level=0.
REQ-025 Reset mid-operation SHALL discard all queued events and abort any pending push on the same edge.
REQ-026 overflow SHALL clear only on reset.

Configuration
REQ-027 Macro LATCH_EDGE_CAPTURE_TIMESTAMP_EN: when defined, the ts counter exists and ev_data[TSW-1:0] carries the timestamp.
REQ-028 Without LATCH_EDGE_CAPTURE_TIMESTAMP_EN, the ts counter SHALL be absent and ev_data[TSW-1:0] SHALL be constant 0; port widths SHALL be unchanged.

Verification
REQ-029 Reset, hold q=1, release, ev_ready=0 for 10 cycles -> level=1, ev_valid=0, no event.
REQ-030 Release reset with q=0 (RUN reached), raise q before edge k -> ev_valid=1 after edge k+2, ev_data={1,0,ts}; with timestamp enabled ts=k+2 cycles since release minus 1.
REQ-031 ev_ready=0, toggle q every 4 cycles for 6 toggles, DEPTH=4 -> 4 events held, alternating rise/fall, overflow=1 after 5th toggle.
REQ-032 FIFO full with ev_ready=1 on the same edge as a new edge push -> head popped, new event stored, overflow stays 0, ev_valid stays 1.
REQ-033 Three queued events, clrn=0 for one cycle -> ev_valid=0, overflow=0, ts=0 next cycle.
REQ-034 Run 300 cycles with TSW=8, timestamp enabled, one rise at cycle 260 after release -> recorded ts=(event cycle mod 256), demonstrating wrap.

Source files
------------

// File: rtl/latch_edge_capture.sv
// latch_edge_capture: synchronises an asynchronous D-latch output, detects its
// rising/falling edges once the synchroniser is primed, and queues each edge as
// {rise, fall, timestamp} in a small FIFO with a sticky overflow flag.
// Optional feature macro: LATCH_EDGE_CAPTURE_TIMESTAMP_EN (timestamp counter;
// without it the timestamp field of every event is constant zero).
module latch_edge_capture #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TSW   = 8
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           q,
  input  logic           ev_ready,
  output logic           ev_valid,
  output logic [TSW+1:0] ev_data,
  output logic           overflow,
  output logic           level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = TSW + 2;

  typedef enum logic [1:0] {
    PRIME0 = 2'd0,
    PRIME1 = 2'd1,
    RUN    = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   run_c;

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  logic rise_c;
  logic fall_c;
  logic push_c;
  logic pop_c;
  logic full_c;
  logic push_ok_c;
  logic drop_c;

  logic [TSW-1:0] ts_c;
  logic [EW-1:0]  entry_c;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          ev_valid_q, ev_valid_d;
  logic [EW-1:0] ev_data_q, ev_data_d;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= PRIME0;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: two priming edges after reset, then RUN until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME0:  state_d = PRIME1;
      PRIME1:  state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = PRIME0;
    endcase
  end

  // FSM outputs: edge detection is only enabled in RUN
  always_comb begin
    run_c = 1'b0;
    if (state_q == RUN) begin
      run_c = 1'b1;
    end
  end

  // Synchroniser chain; while priming, s3 is aligned with the new s2 so the
  // first RUN comparison never reports the reset-to-level step as an edge
  always_comb begin
    s1_d = q;
    s2_d = s1_q;
    s3_d = s2_q;
    if (!run_c) begin
      s3_d = s2_d;
    end
  end

`ifdef LATCH_EDGE_CAPTURE_TIMESTAMP_EN
  logic [TSW-1:0] ts_q, ts_d;

  // Free-running timestamp, wraps naturally at 2^TSW
  always_comb begin
    ts_d = ts_q + TSW'(1);
  end

  // Timestamp register
  always_ff @(posedge clk) begin
    if (!clrn) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign ts_c = ts_q;
`else
  assign ts_c = '0;
`endif

  // Edge detection and FIFO handshake decode
  always_comb begin
    rise_c    = s2_q & ~s3_q;
    fall_c    = ~s2_q & s3_q;
    push_c    = run_c & (rise_c | fall_c);
    pop_c     = ev_valid_q & ev_ready;
    full_c    = (count_q == CW'(DEPTH));
    push_ok_c = push_c & (~full_c | pop_c);
    drop_c    = push_c & full_c & ~pop_c;
    entry_c   = {rise_c, fall_c, ts_c};
  end

  // FIFO next state: pop frees the head before a push lands at the tail
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = entry_c;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (drop_c) begin
      ovf_d = 1'b1;
    end
    count_d = count_q + CW'(push_ok_c) - CW'(pop_c);
  end

  // Registered head-of-queue view, zero when empty
  always_comb begin
    ev_valid_d = (count_d != '0);
    ev_data_d  = '0;
    if (ev_valid_d) begin
      ev_data_d = mem_d[rd_ptr_d];
    end
  end

  // Control and output registers; reset wins over any pending push
  always_ff @(posedge clk) begin
    if (!clrn) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_data_q  <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      ev_valid_q <= ev_valid_d;
      ev_data_q  <= ev_data_d;
    end
  end

  // Event storage; contents are don't-care after reset since pointers clear
  always_ff @(posedge clk) begin
    if (clrn) begin
      mem_q <= mem_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_data  = ev_data_q;
  assign overflow = ovf_q;
  assign level    = s2_q;

endmodule

// File: tb/tb_latch_edge_capture.sv
// Bench for latch_edge_capture: directed scenarios plus randomized traffic,
// every cycle compared against a sample-history / queue reference model.
module tb_latch_edge_capture;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TSW   = 8;
  localparam int unsigned EW    = TSW + 2;
`ifdef LATCH_EDGE_CAPTURE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clrn;
  logic          q;
  logic          ev_ready;
  logic          ev_valid;
  logic [EW-1:0] ev_data;
  logic          overflow;
  logic          level;

  always #5 clk = ~clk;

  latch_edge_capture #(.DEPTH(DEPTH), .TSW(TSW)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .q        (q),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_data  (ev_data),
    .overflow (overflow),
    .level    (level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: samp[n] is q as seen at edge n after reset (samp[0] is the
  // reset value), m_n counts edges since the reset edge, mq is the event queue.
  logic [EW-1:0] mq[$];
  bit            samp[$];
  bit            m_ovf;
  int            m_n;

  function automatic logic [EW-1:0] mk_ev(bit rise, int n);
    logic [TSW-1:0] ts;
    ts = TS_EN ? TSW'(n - 1) : '0;
    return {rise, ~rise, ts};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // An edge of q first seen at edge k surfaces as a push at edge k+2, stamped
  // with the cycle count before that edge; pushes need two prior real samples.
  task automatic model_edge(input bit c, input bit qv, input bit rdy);
    bit pop;
    bit push;
    bit rise;
    if (!c) begin
      mq.delete();
      samp.delete();
      samp.push_back(1'b0);
      m_ovf = 1'b0;
      m_n   = 0;
    end else begin
      m_n++;
      pop  = (mq.size() > 0) && rdy;
      push = (m_n >= 4) && (samp[m_n-2] != samp[m_n-3]);
      rise = samp[m_n-2];
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(mk_ev(rise, m_n));
        else m_ovf = 1'b1;
      end
      samp.push_back(qv);
    end
  endtask

  task automatic compare_model();
    bit exp_valid;
    exp_valid = (mq.size() > 0);
    check("ev_valid", EW'(ev_valid), EW'(exp_valid));
    if (exp_valid) check("ev_data", ev_data, mq[0]);
    check("overflow", EW'(overflow), EW'(m_ovf));
    check("level", EW'(level), EW'((m_n == 0) ? 1'b0 : samp[m_n-1]));
  endtask

  // One clock: drive, model the edge, compare at the falling edge
  task automatic cyc(input bit c, input bit qv, input bit rdy);
    clrn     = c;
    q        = qv;
    ev_ready = rdy;
    @(posedge clk);
    model_edge(c, qv, rdy);
    @(negedge clk);
    compare_model();
  endtask

  // Just after a reset with q=0: rise q at edge 6, event appears after edge 8
  task automatic latency_probe(input string tag);
    for (int e = 1; e <= 5; e++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check({tag, "_valid_k1"}, EW'(ev_valid), EW'(1'b0));
    cyc(1'b1, 1'b1, 1'b0);
    check({tag, "_valid_k2"}, EW'(ev_valid), EW'(1'b1));
    check({tag, "_data_k2"}, ev_data, {2'b10, (TS_EN ? TSW'(7) : TSW'(0))});
  endtask

  initial begin
    logic qv;
    int unsigned tgl_den;
    int unsigned rdy_pct;
    bit c;

    clrn = 1'b0; q = 1'b0; ev_ready = 1'b0;
    @(negedge clk);

    // Reset values
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_valid", EW'(ev_valid), EW'(1'b0));
    check("rst_data", ev_data, EW'(0));
    check("rst_ovf", EW'(overflow), EW'(1'b0));
    check("rst_level", EW'(level), EW'(1'b0));

    // q held high through reset and release: no spurious event
    cyc(1'b0, 1'b1, 1'b0);
    repeat (10) cyc(1'b1, 1'b1, 1'b0);
    check("hold_level", EW'(level), EW'(1'b1));
    check("hold_valid", EW'(ev_valid), EW'(1'b0));

    // First-event latency and timestamp
    cyc(1'b0, 1'b0, 1'b0);
    latency_probe("lat");

    // Overflow with consumer stalled: 6 toggles into a 4-deep FIFO
    cyc(1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    qv = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      qv = ~qv;
      repeat (4) cyc(1'b1, qv, 1'b0);
      check($sformatf("ovf_after_toggle%0d", t), EW'(overflow), EW'(t >= 5));
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d", i), EW'(ev_data[EW-1:EW-2]), EW'((i % 2 == 0) ? 2'b10 : 2'b01));
      cyc(1'b1, qv, 1'b1);
    end
    check("ovf_drained_valid", EW'(ev_valid), EW'(1'b0));
    check("ovf_sticky", EW'(overflow), EW'(1'b1));

    // Full FIFO: push and pop on the same edge
    cyc(1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    qv = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      qv = ~qv;
      repeat (4) cyc(1'b1, qv, 1'b0);
    end
    qv = ~qv;
    cyc(1'b1, qv, 1'b0);
    cyc(1'b1, qv, 1'b0);
    cyc(1'b1, qv, 1'b1);
    check("fullpp_ovf", EW'(overflow), EW'(1'b0));
    check("fullpp_valid", EW'(ev_valid), EW'(1'b1));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fullpp_drain%0d", i), EW'(ev_data[EW-1:EW-2]), EW'((i % 2 == 0) ? 2'b01 : 2'b10));
      cyc(1'b1, qv, 1'b1);
    end
    check("fullpp_empty", EW'(ev_valid), EW'(1'b0));

    // Reset with queued events, overflow set and a push pending on the reset edge
    cyc(1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    qv = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      qv = ~qv;
      repeat (4) cyc(1'b1, qv, 1'b0);
    end
    check("midrst_pre_ovf", EW'(overflow), EW'(1'b1));
    qv = ~qv;
    cyc(1'b1, qv, 1'b0);
    cyc(1'b1, qv, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("midrst_valid", EW'(ev_valid), EW'(1'b0));
    check("midrst_ovf", EW'(overflow), EW'(1'b0));
    latency_probe("midrst");

    // Timestamp wrap: rise at edge 260, recorded stamp 261 mod 256
    cyc(1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 259; e++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("wrap_valid_k1", EW'(ev_valid), EW'(1'b0));
    cyc(1'b1, 1'b1, 1'b0);
    check("wrap_data", ev_data, {2'b10, (TS_EN ? TSW'(5) : TSW'(0))});
    repeat (38) cyc(1'b1, 1'b1, 1'b1);

    // Randomized traffic with occasional resets
    qv = 1'b0;
    cyc(1'b0, qv, 1'b0);
    for (int ph = 0; ph < 4; ph++) begin
      tgl_den = 32'd2 << ph;
      rdy_pct = 32'd20 + 32'd25 * 32'(ph);
      for (int i = 0; i < 500; i++) begin
        c = ($urandom_range(0, 199) != 0);
        if ($urandom_range(0, tgl_den - 1) == 0) qv = ~qv;
        cyc(c, qv, ($urandom_range(0, 99) < rdy_pct));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
